// File: rtl/led_seq_pkg.sv
// Shared register map, mode codes, FSM encoding and STATUS layout for the LED sequencer.
package led_seq_pkg;

    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_PATTERN = 2'd1;
    localparam logic [1:0] REG_PERIOD  = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    localparam int CTRL_EN_BIT    = 0;
    localparam int STATUS_DIR_BIT = 15;

    typedef enum logic [2:0] {
        MODE_STATIC = 3'd0,
        MODE_BLINK  = 3'd1,
        MODE_ROTATE = 3'd2,
        MODE_COUNT  = 3'd3,
        MODE_BOUNCE = 3'd4
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_PUSH  = 3'd3,
        ST_CLEAR = 3'd4
    } state_e;

    function automatic logic [15:0] status_word(input logic dir, input logic [7:0] frame);
        logic [15:0] w;
        w                 = 16'h0000;
        w[STATUS_DIR_BIT] = dir;
        w[7:0]            = frame;
        return w;
    endfunction

endpackage

// File: rtl/led_seq_tick.sv
// Prescaler plus period counter; emits a one-cycle step every max(period,1) ticks.
// A restart clears both counters and suppresses any step in the same cycle.
module led_seq_tick
    import led_seq_pkg::*;
#(
    parameter int unsigned PRESCALE = 50000
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        run_i,
    input  logic        restart_i,
    input  logic [15:0] period_i,
    output logic        step_o
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_d;
    logic [15:0]   per_q;
    logic [15:0]   per_d;
    logic [15:0]   per_max;
    logic          tick;
    logic          per_hit;

    // PERIOD of 0 is treated as 1
    assign per_max = (period_i == 16'd0) ? 16'd0 : period_i - 16'd1;
    assign tick    = run_i && (pre_q == PRE_MAX);
    assign per_hit = (per_q == per_max);
    assign step_o  = tick && per_hit && !restart_i;

    always_comb begin
        pre_d = pre_q + PW'(1);
        per_d = per_q;
        if (tick) begin
            pre_d = '0;
            per_d = per_hit ? 16'd0 : per_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i || restart_i || !run_i) begin
            pre_q <= '0;
            per_q <= 16'd0;
        end else begin
            pre_q <= pre_d;
            per_q <= per_d;
        end
    end

endmodule

// File: rtl/led_pattern_sequencer.sv
// CPU-programmed LED frame engine: config write -> LED write two cycles later, step -> one cycle later.
// Define LED_SEQ_BOUNCE_EN to enable mode 4 (bounce); otherwise modes 4-7 behave as static.
module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int unsigned PRESCALE   = 50000,
    parameter logic [15:0] PERIOD_RST = 16'd10
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        cs_i,
    input  logic        we_i,
    input  logic [1:0]  reg_sel_i,
    input  logic [15:0] in_i,
    output logic [15:0] out_o,
    output logic        led_cs_o,
    output logic        led_we_o,
    output logic [1:0]  led_reg_sel_o,
    output logic [15:0] led_in_o
);

    logic [3:0]  ctrl_q;
    logic [7:0]  pattern_q;
    logic [15:0] period_q;
    logic [7:0]  frame_q;
    logic        dir_q;
    state_e      state_q;
    logic        led_cs_q;
    logic [7:0]  led_dat_q;

    logic [7:0]  nxt_frame_d;
    logic        nxt_dir_d;
    mode_e       mode;
    logic        wr, wr_ctrl, wr_pat, wr_per;
    logic        cfg_load, cfg_clear, restart, run, step;

    assign wr      = cs_i && we_i;
    assign wr_ctrl = wr && (reg_sel_i == REG_CTRL);
    assign wr_pat  = wr && (reg_sel_i == REG_PATTERN);
    assign wr_per  = wr && (reg_sel_i == REG_PERIOD);

    assign cfg_load  = (wr_ctrl && in_i[CTRL_EN_BIT]) || (wr_pat && ctrl_q[CTRL_EN_BIT]);
    assign cfg_clear = wr_ctrl && !in_i[CTRL_EN_BIT] && ctrl_q[CTRL_EN_BIT];
    assign restart   = cfg_load || cfg_clear || wr_per;
    assign run       = (state_q == ST_RUN) || (state_q == ST_PUSH);
    assign mode      = mode_e'(ctrl_q[3:1]);

    led_seq_tick #(
        .PRESCALE (PRESCALE)
    ) u_tick (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .run_i     (run),
        .restart_i (restart),
        .period_i  (period_q),
        .step_o    (step)
    );

    always_comb begin
        nxt_frame_d = pattern_q;
        nxt_dir_d   = dir_q;
        case (mode)
            MODE_STATIC: nxt_frame_d = pattern_q;
            MODE_BLINK:  nxt_frame_d = (frame_q == 8'h00) ? pattern_q : 8'h00;
            MODE_ROTATE: nxt_frame_d = {frame_q[6:0], frame_q[7]};
            MODE_COUNT:  nxt_frame_d = frame_q + 8'd1;
`ifdef LED_SEQ_BOUNCE_EN
            // Direction reverses on the edge bit itself, so the frame never shifts out
            MODE_BOUNCE: begin
                if (!dir_q) begin
                    nxt_dir_d   = frame_q[7];
                    nxt_frame_d = frame_q[7] ? {1'b0, frame_q[7:1]} : {frame_q[6:0], 1'b0};
                end else begin
                    nxt_dir_d   = !frame_q[0];
                    nxt_frame_d = frame_q[0] ? {frame_q[6:0], 1'b0} : {1'b0, frame_q[7:1]};
                end
            end
`endif
            default:     nxt_frame_d = pattern_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ctrl_q    <= 4'h0;
            pattern_q <= 8'h00;
            period_q  <= PERIOD_RST;
            frame_q   <= 8'h00;
            dir_q     <= 1'b0;
            state_q   <= ST_IDLE;
            led_cs_q  <= 1'b0;
            led_dat_q <= 8'h00;
        end else begin
            led_cs_q  <= 1'b0;
            led_dat_q <= 8'h00;
            if (wr_ctrl) ctrl_q    <= in_i[3:0];
            if (wr_pat)  pattern_q <= in_i[7:0];
            if (wr_per)  period_q  <= in_i;

            // CPU configuration writes preempt whatever the FSM was doing
            if (cfg_load) begin
                state_q <= ST_LOAD;
            end else if (cfg_clear) begin
                state_q <= ST_CLEAR;
            end else begin
                case (state_q)
                    ST_IDLE: state_q <= ST_IDLE;
                    ST_LOAD: begin
                        frame_q   <= pattern_q;
                        dir_q     <= 1'b0;
                        led_cs_q  <= 1'b1;
                        led_dat_q <= pattern_q;
                        state_q   <= ST_PUSH;
                    end
                    ST_RUN, ST_PUSH: begin
                        if (step) begin
                            frame_q   <= nxt_frame_d;
                            dir_q     <= nxt_dir_d;
                            led_cs_q  <= 1'b1;
                            led_dat_q <= nxt_frame_d;
                            state_q   <= ST_PUSH;
                        end else begin
                            state_q   <= ST_RUN;
                        end
                    end
                    ST_CLEAR: begin
                        frame_q   <= 8'h00;
                        led_cs_q  <= 1'b1;
                        led_dat_q <= 8'h00;
                        state_q   <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        out_o = 16'h0000;
        if (cs_i) begin
            case (reg_sel_i)
                REG_CTRL:    out_o = {12'h000, ctrl_q};
                REG_PATTERN: out_o = {8'h00, pattern_q};
                REG_PERIOD:  out_o = period_q;
                default:     out_o = status_word(dir_q, frame_q);
            endcase
        end
    end

    assign led_cs_o      = led_cs_q;
    assign led_we_o      = led_cs_q;
    assign led_reg_sel_o = 2'd0;
    assign led_in_o      = {8'h00, led_dat_q};

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Scoreboard bench: stimulus queues expected LED writes (cycle, value); a negedge monitor pops and compares.
module tb_led_pattern_sequencer;
    import led_seq_pkg::*;

    localparam int          PRESCALE   = 2;
    localparam logic [15:0] PERIOD_RST = 16'd10;

    logic        clk_i   = 1'b0;
    logic        reset_i = 1'b1;
    logic        cs_i    = 1'b0;
    logic        we_i    = 1'b0;
    logic [1:0]  reg_sel_i = 2'd0;
    logic [15:0] in_i    = 16'h0000;
    logic [15:0] out_o;
    logic        led_cs_o, led_we_o;
    logic [1:0]  led_reg_sel_o;
    logic [15:0] led_in_o;

    led_pattern_sequencer #(
        .PRESCALE   (PRESCALE),
        .PERIOD_RST (PERIOD_RST)
    ) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .cs_i          (cs_i),
        .we_i          (we_i),
        .reg_sel_i     (reg_sel_i),
        .in_i          (in_i),
        .out_o         (out_o),
        .led_cs_o      (led_cs_o),
        .led_we_o      (led_we_o),
        .led_reg_sel_o (led_reg_sel_o),
        .led_in_o      (led_in_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int         cyc;
        logic [7:0] val;
    } exp_t;

    exp_t        exp_q[$];
    int          cyc      = 0;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] cur_per  = PERIOD_RST;
    logic [3:0]  cur_ctrl = 4'h0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, expv, cyc);
        end
    endtask

    // Reference model: next frame from the mode rules, returns {dir, frame}
    function automatic logic [8:0] model_next(input int mode, input int pat, input int f, input logic d);
        int   v;
        logic nd;
        v  = pat;
        nd = d;
        case (mode)
            1: v = (f == 0) ? pat : 0;
            2: v = (f * 2) % 256 + f / 128;
            3: v = (f + 1) % 256;
`ifdef LED_SEQ_BOUNCE_EN
            4: begin
                if (f == 0) v = 0;
                else if (!d) begin
                    if (f >= 128) begin nd = 1'b1; v = f / 2; end
                    else v = f * 2;
                end else begin
                    if (f % 2 == 1) begin nd = 1'b0; v = (f * 2) % 256; end
                    else v = f / 2;
                end
            end
`endif
            default: v = pat;
        endcase
        return {nd, v[7:0]};
    endfunction

    always @(negedge clk_i) begin
        exp_t e;
        check("led_we_eq_cs", {31'h0, led_we_o}, {31'h0, led_cs_o});
        if (led_cs_o) begin
            check("led_reg_sel", {30'h0, led_reg_sel_o}, 32'h0);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got led_in=%0h at cycle %0d, expected no write", led_in_o, cyc);
            end else begin
                e = exp_q.pop_front();
                check("led_in", {16'h0, led_in_o}, {24'h0, e.val});
                check("led_write_cycle", cyc, e.cyc);
            end
        end else begin
            check("led_in_idle", {16'h0, led_in_o}, 32'h0);
        end
    end

    task automatic tick1();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_lbl(input int x);
        while (cyc < x) tick1();
    endtask

    task automatic cpu_wr(input logic [1:0] sel, input logic [15:0] d, output int lbl);
        lbl       = cyc;
        cs_i      = 1'b1;
        we_i      = 1'b1;
        reg_sel_i = sel;
        in_i      = d;
        if (sel == REG_CTRL)   cur_ctrl = d[3:0];
        if (sel == REG_PERIOD) cur_per  = d;
        tick1();
        cs_i = 1'b0;
        we_i = 1'b0;
        in_i = 16'h0000;
    endtask

    task automatic cpu_rd(input logic [1:0] sel, output logic [15:0] v);
        cs_i      = 1'b1;
        we_i      = 1'b0;
        reg_sel_i = sel;
        #1;
        v = out_o;
        tick1();
        cs_i = 1'b0;
    endtask

    task automatic run_load(input int lbl, input int mode, input logic [7:0] pat, input int n,
                            input int sp, input bit rst_last, output int w);
        logic [7:0]  f;
        logic        d;
        logic [8:0]  nx;
        logic [15:0] rd;
        logic [8:0]  st[$];
        f = pat;
        d = 1'b0;
        w = lbl;
        for (int k = 0; k <= n; k++) begin
            if (k > 0) begin
                nx = model_next(mode, int'(pat), int'(f), d);
                d  = nx[8];
                f  = nx[7:0];
            end
            st.push_back({d, f});
            exp_q.push_back('{lbl + 2 + sp * k, f});
        end
        for (int k = 0; k <= n; k++) begin
            w = lbl + 2 + sp * k;
            wait_lbl(w);
            if (rst_last && k == n) reset_i = 1'b1;
            cpu_rd(REG_STATUS, rd);
            check("status", {16'h0, rd}, {16'h0, st[k][8], 7'h00, st[k][7:0]});
        end
    endtask

    // kind 0: disable afterwards; 1: PATTERN write 8'h11 on a step cycle, then disable; 2: reset on last PUSH
    task automatic session(input int mode, input logic [7:0] pat, input int per, input int n, input int kind);
        int          lbl, w, sp, x;
        logic [15:0] rd;
        if (per >= 0) cpu_wr(REG_PERIOD, 16'(per), lbl);
        cpu_wr(REG_PATTERN, {8'h00, pat}, lbl);
        cpu_wr(REG_CTRL, {12'h000, 3'(mode), 1'b1}, lbl);
        sp = PRESCALE * ((cur_per == 16'd0) ? 1 : int'(cur_per));
        run_load(lbl, mode, pat, n, sp, kind == 2, w);
        if (kind == 2) begin
            check("led_cs_after_reset", {31'h0, led_cs_o}, 32'h0);
            reset_i  = 1'b0;
            cur_per  = PERIOD_RST;
            cur_ctrl = 4'h0;
            tick1();
            cpu_rd(REG_CTRL, rd);
            check("ctrl_after_reset", {16'h0, rd}, 32'h0);
            cpu_rd(REG_PERIOD, rd);
            check("period_after_reset", {16'h0, rd}, {16'h0, PERIOD_RST});
        end else begin
            if (kind == 1) begin
                wait_lbl(w + sp - 1);
                cpu_wr(REG_PATTERN, 16'h0011, lbl);
                run_load(lbl, mode, 8'h11, n, sp, 1'b0, w);
            end
            x = w + 1 + int'($urandom_range(0, sp - 2));
            wait_lbl(x);
            cpu_wr(REG_CTRL, {12'h000, cur_ctrl[3:1], 1'b0}, lbl);
            exp_q.push_back('{lbl + 2, 8'h00});
            wait_lbl(lbl + 2 + 2 * sp + 2);
            cpu_rd(REG_STATUS, rd);
            check("frame_after_clear", {24'h0, rd[7:0]}, 32'h0);
            cpu_rd(REG_CTRL, rd);
            check("ctrl_disabled", {16'h0, rd}, {28'h0, cur_ctrl});
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

    initial begin
        logic [15:0] rd;
        reset_i = 1'b1;
        repeat (3) tick1();
        reset_i   = 1'b0;
        reg_sel_i = REG_PERIOD;
        #1;
        check("out_without_cs", {16'h0, out_o}, 32'h0);
        for (int i = 0; i < 20; i++) begin
            check("led_cs_after_reset_idle", {31'h0, led_cs_o}, 32'h0);
            tick1();
        end
        cpu_rd(REG_CTRL, rd);
        check("reset_ctrl", {16'h0, rd}, 32'h0);
        cpu_rd(REG_PATTERN, rd);
        check("reset_pattern", {16'h0, rd}, 32'h0);
        cpu_rd(REG_PERIOD, rd);
        check("reset_period", {16'h0, rd}, {16'h0, PERIOD_RST});
        cpu_rd(REG_STATUS, rd);
        check("reset_status", {16'h0, rd}, 32'h0);

        session(0, 8'hA5, -1, 2, 0);   // static, PERIOD left at reset value
        session(2, 8'h81,  1, 6, 0);   // rotate
        session(3, 8'hFE,  2, 2, 0);   // count wraps FF -> 00
        session(1, 8'h3C,  0, 2, 0);   // blink, PERIOD=0 acts as 1
        session(2, 8'h00,  1, 2, 0);   // rotate of zero pattern
        session(3, 8'h50,  1, 2, 1);   // PATTERN write collides with a step
        session(4, 8'h40,  1, 3, 0);   // bounce (static when feature is off)
        session(4, 8'h01,  2, 4, 0);
        session(2, 8'h01,  1, 2, 2);   // reset during PUSH

        for (int i = 0; i < 10; i++) begin
            session(int'($urandom_range(0, 7)), 8'($urandom), int'($urandom_range(0, 3)),
                    int'($urandom_range(1, 4)), int'($urandom_range(0, 1)));
        end

        repeat (4) tick1();
        check("scoreboard_drained", exp_q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
